// File: rtl/front_panel_pkg.sv
// Shared definitions for the front-panel loader: FSM state encoding and
// the meaning of the mode switch.
package front_panel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_ADDR = 3'd1,
        ST_WRITE     = 3'd2,
        ST_INC       = 3'd3,
        ST_WAIT_REL  = 3'd4
    } fp_state_t;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_DATA = 1'b1;

    function automatic logic is_busy_state(input fp_state_t s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/front_panel_loader_if.sv
// Bundle between the operator panel (switches, button) and the loader,
// plus the memory-side outputs and a debug view of the loader FSM.
interface front_panel_loader_if #(
    parameter int WORD_SIZE  = 8,
    parameter int ADDR_WIDTH = 8
);
    import front_panel_pkg::*;

    logic                  btn_raw;
    logic                  mode;
    logic [WORD_SIZE-1:0]  sw_in;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WORD_SIZE-1:0]  wr_data;
    // wr_en is a single-cycle strobe with no back-pressure: memory must take
    // wr_data at addr on the cycle it is high; addr and wr_data are stable then.
    logic                  wr_en;
    logic                  busy;
    fp_state_t             state;

    modport master (
        output btn_raw, mode, sw_in,
        input  addr, wr_data, wr_en, busy, state
    );

    modport slave (
        input  btn_raw, mode, sw_in,
        output addr, wr_data, wr_en, busy, state
    );

endinterface

// File: rtl/button_debounce.sv
// Synchronizes and debounces a bouncy active-high button and emits a
// one-cycle pulse on each accepted press.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 3);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    // Arming needs more low samples than the reset-cleared synchronizer can
    // fake, so a button held across reset is never seen as a fresh press.
    localparam logic [CW-1:0] ARM_LAST = CW'(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic [CW-1:0] arm_cnt;
    logic          armed;
    logic          differ;
    logic          flip;

    assign differ = (sync2 != level);
    assign flip   = differ && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            level      <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            rise_pulse <= flip && sync2 && armed;
            if (!differ) begin
                cnt <= '0;
            end else if (flip) begin
                cnt   <= '0;
                level <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_cnt <= '0;
            armed   <= 1'b0;
        end else if (!armed) begin
            if (sync2) begin
                arm_cnt <= '0;
            end else if (arm_cnt == ARM_LAST) begin
                armed <= 1'b1;
            end else begin
                arm_cnt <= arm_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/front_panel_loader.sv
// Front-panel loader: a debounced deposit button either latches an address
// or writes a data word, then auto-increments the address.
module front_panel_loader
    import front_panel_pkg::*;
#(
    parameter int WORD_SIZE       = 8,
    parameter int ADDR_WIDTH      = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int AUTO_INC        = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    front_panel_loader_if.slave  bus
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    logic                  level;
    logic                  press;
    fp_state_t             state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WORD_SIZE-1:0]  data_q;
    logic                  wr_en_q;
    logic                  busy_q;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw        (bus.btn_raw),
        .level      (level),
        .rise_pulse (press)
    );

    // Outputs are registered on entry to a state, so each state's action is
    // visible for exactly the cycle the FSM sits in it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (press) begin
                        busy_q <= 1'b1;
                        if (bus.mode == MODE_ADDR) begin
                            state  <= ST_LOAD_ADDR;
                            addr_q <= bus.sw_in[ADDR_WIDTH-1:0];
                        end else begin
                            state   <= ST_WRITE;
                            data_q  <= bus.sw_in;
                            wr_en_q <= 1'b1;
                        end
                    end
                end
                ST_LOAD_ADDR: begin
                    state <= ST_WAIT_REL;
                end
                ST_WRITE: begin
                    state <= ST_INC;
                    if (AUTO_INC != 0) begin
                        addr_q <= addr_q + ADDR_ONE;
                    end
                end
                ST_INC: begin
                    state <= ST_WAIT_REL;
                end
                ST_WAIT_REL: begin
                    if (!level) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.addr    = addr_q;
    assign bus.wr_data = data_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.busy    = busy_q;
    assign bus.state   = state;

endmodule
